// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control sequencer: opcodes, states, mux encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] JAL   = 6'b000011;

  // Funct field IR[5:0]
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // ALU controller opcodes
  localparam logic [5:0] ALUOP_ADD = 6'b100011;
  localparam logic [5:0] ALUOP_SUB = 6'b000100;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JAL     = 4'd9,
    S_JR      = 4'd10,
    S_FAULT   = 4'd15
  } state_t;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // States that own the shared memory port and therefore wait on MemReady
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
// Latency: n/a (wires only).
// Backpressure: MemReady from the datapath memory stalls the master in memory states.
// Ports: Opcode/Funct/MemReady toward the sequencer; enables, mux selects, ALUOp,
//        Fault and debug State toward the datapath.
interface multicycle_control_fsm_if;
  import mips_ctrl_pkg::*;

  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       MemReady;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [5:0] ALUOp;
  logic       Fault;
  logic [3:0] State;

  modport master (
    input  Opcode, Funct, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
           RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, Fault, State
  );

  modport slave (
    output Opcode, Funct, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
           RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, Fault, State
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags when the allowed budget is used up.
// Latency: expired is combinational in the cycle the count reaches MEM_TIMEOUT-1 while waiting.
// Backpressure: none; clear has priority over waiting.
// Ports: clk, reset (sync, high), clear (zero the count), waiting (count this cycle), expired.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (waiting) begin
      count <= count + 8'd1;
    end
  end

  // Only meaningful while still waiting: a ready in the last allowed cycle wins.
  assign expired = waiting && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencer: fetch/decode/execute/memory/write-back control, one state at a time.
// Latency: beq/jal/jr 3 cycles, R-type/addi/andi/sw 4, lw 5, plus one per MemReady-low cycle.
// Backpressure: holds in FETCH/MEMRD/MEMWR until MemReady; faults after MEM_TIMEOUT wait cycles.
// Ports: clk, reset (sync, high), bus (master modport: IR fields + MemReady in, controls out).
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_fsm_if.master    bus
);

  state_t state_q, state_d;
  logic   in_mem, waiting, expired;

  // Counter sits at zero outside memory states, so every memory state is entered with a fresh count.
  assign in_mem  = is_mem_state(state_q);
  assign waiting = in_mem && !bus.MemReady;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_mem || bus.MemReady),
    .waiting (waiting),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.MemReady)  state_d = S_DECODE;
        else if (expired)  state_d = S_FAULT;
      end
      S_DECODE: begin
        case (bus.Opcode)
          RTYPE:       state_d = (bus.Funct == FUNCT_JR) ? S_JR : S_EXEC;
          LW, SW:      state_d = S_MEMADDR;
          ADDI, ANDI:  state_d = S_EXEC;
          BEQ:         state_d = S_BRANCH;
          JAL:         state_d = S_JAL;
          default:     state_d = S_FAULT;
        endcase
      end
      S_MEMADDR: state_d = (bus.Opcode == LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.MemReady)  state_d = S_MEMWB;
        else if (expired)  state_d = S_FAULT;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR: begin
        if (bus.MemReady)  state_d = S_FETCH;
        else if (expired)  state_d = S_FAULT;
      end
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JAL:     state_d = S_FETCH;
      S_JR:      state_d = S_FETCH;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FAULT;
    endcase
  end

  // Output decode
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
  logic       fault;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [5:0] alu_op;
  logic [3:0] state_out;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    fault         = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = MEMTOREG_ALUOUT;
    alu_src_b     = SRCB_REGB;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    state_out     = state_q;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // PC+4 and IR load happen only in the cycle memory delivers the word.
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = MEMTOREG_MDR;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (bus.Opcode == RTYPE) ? SRCB_REGB : SRCB_IMM;
        alu_op    = bus.Opcode;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        mem_to_reg = MEMTOREG_ALUOUT;
        reg_dst    = (bus.Opcode == RTYPE) ? REGDST_RD : REGDST_RT;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = REGDST_RA;
        mem_to_reg = MEMTOREG_PC;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_REGA;
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b1;
    endcase
    // Reset quiets every output, including the debug state and the combinational fetch enables.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      fault         = 1'b0;
      reg_dst       = 2'b00;
      mem_to_reg    = 2'b00;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = 6'b000000;
      state_out     = 4'd0;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCWriteCond = pc_write_cond;
  assign bus.IorD        = iord;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IRWrite     = ir_write;
  assign bus.RegWrite    = reg_write;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.PCSource    = pc_source;
  assign bus.ALUOp       = alu_op;
  assign bus.Fault       = fault;
  assign bus.State       = state_out;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control sequencer, built with a 4-cycle memory timeout.
// Latency: n/a.
// Backpressure: MemReady is driven per cycle from the stimulus tables.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.MemReady = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Opcode = LW; bus.Funct = 6'd0; bus.MemReady = 1'b1;
    #1;
    total++; if ({bus.State, bus.MemRead, bus.IRWrite, bus.PCWrite, bus.Fault} !== 8'd0) begin bad++;
      $display("FAIL reset_outputs: got %b want 00000000", {bus.State, bus.MemRead, bus.IRWrite, bus.PCWrite, bus.Fault}); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.State); end
    total++; if ({bus.MemRead, bus.IRWrite, bus.PCWrite, bus.ALUSrcB} !== 5'b11101) begin bad++;
      $display("FAIL reset_fetch_outs: got %b want 11101", {bus.MemRead, bus.IRWrite, bus.PCWrite, bus.ALUSrcB}); end
  endtask

  task automatic test_lw();
    logic [3:0] st [0:4];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    apply_reset();
    bus.Opcode = LW; bus.Funct = 6'd0; bus.MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.State !== st[i]) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.State, st[i]); end
      total++; if ({bus.RegWrite, bus.MemtoReg} !== ((i == 4) ? 3'b101 : 3'b000)) begin bad++;
        $display("FAIL lw_wb[%0d]: got %b want %b", i, {bus.RegWrite, bus.MemtoReg}, (i == 4) ? 3'b101 : 3'b000); end
      if (i == 3) begin
        total++; if ({bus.MemRead, bus.IorD} !== 2'b11) begin bad++; $display("FAIL lw_memrd: got %b want 11", {bus.MemRead, bus.IorD}); end
      end
      tick();
    end
    #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL lw_return: got %0d want 0", bus.State); end
  endtask

  task automatic test_sw_wait();
    logic [3:0] st [0:6];
    logic       mr [0:6];
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    bus.Opcode = SW; bus.Funct = 6'd0;
    for (int i = 0; i < 7; i++) begin
      bus.MemReady = mr[i];
      #1;
      total++; if (bus.State !== st[i]) begin bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, bus.State, st[i]); end
      if (i >= 3) begin
        total++; if ({bus.MemWrite, bus.IorD, bus.RegWrite, bus.PCWrite} !== 4'b1100) begin bad++;
          $display("FAIL sw_memwr[%0d]: got %b want 1100", i, {bus.MemWrite, bus.IorD, bus.RegWrite, bus.PCWrite}); end
      end
      tick();
    end
    #1;
    total++; if ({bus.State, bus.Fault} !== 5'b00000) begin bad++; $display("FAIL sw_return: got %b want 00000", {bus.State, bus.Fault}); end
  endtask

  task automatic test_rtype_jr();
    logic [3:0] st [0:3];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    apply_reset();
    bus.Opcode = RTYPE; bus.Funct = 6'b100000; bus.MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (bus.State !== st[i]) begin bad++; $display("FAIL add_state[%0d]: got %0d want %0d", i, bus.State, st[i]); end
      if (i == 1) begin
        total++; if ({bus.ALUSrcA, bus.ALUSrcB} !== 3'b011) begin bad++; $display("FAIL decode_srcs: got %b want 011", {bus.ALUSrcA, bus.ALUSrcB}); end
      end
      if (i == 2) begin
        total++; if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp} !== 9'b1_00_000000) begin bad++;
          $display("FAIL add_exec: got %b want 100000000", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp}); end
      end
      if (i == 3) begin
        total++; if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 5'b1_01_00) begin bad++;
          $display("FAIL add_wb: got %b want 10100", {bus.RegWrite, bus.RegDst, bus.MemtoReg}); end
      end
      tick();
    end
    bus.Funct = FUNCT_JR;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.State !== ((i == 2) ? 4'd10 : 4'(i))) begin bad++;
        $display("FAIL jr_state[%0d]: got %0d want %0d", i, bus.State, (i == 2) ? 10 : i); end
      if (i == 2) begin
        total++; if ({bus.PCWrite, bus.PCSource, bus.RegWrite} !== 4'b1_11_0) begin bad++;
          $display("FAIL jr_outs: got %b want 1110", {bus.PCWrite, bus.PCSource, bus.RegWrite}); end
      end
      tick();
    end
    #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL jr_return: got %0d want 0", bus.State); end
  endtask

  task automatic test_imm_beq();
    apply_reset();
    bus.Opcode = ADDI; bus.Funct = 6'b000101; bus.MemReady = 1'b1;
    tick(); tick();
    #1;
    total++; if ({bus.State, bus.ALUSrcB, bus.ALUOp} !== {4'd6, 2'b10, 6'b001000}) begin bad++;
      $display("FAIL addi_exec: got %b want %b", {bus.State, bus.ALUSrcB, bus.ALUOp}, {4'd6, 2'b10, 6'b001000}); end
    tick();
    #1;
    total++; if ({bus.State, bus.RegWrite, bus.RegDst} !== {4'd7, 1'b1, 2'b00}) begin bad++;
      $display("FAIL addi_wb: got %b want %b", {bus.State, bus.RegWrite, bus.RegDst}, {4'd7, 1'b1, 2'b00}); end
    tick();
    bus.Opcode = BEQ;
    tick(); tick();
    #1;
    total++; if ({bus.State, bus.PCWriteCond, bus.PCWrite, bus.PCSource, bus.ALUOp} !== {4'd8, 1'b1, 1'b0, 2'b01, 6'b000100}) begin bad++;
      $display("FAIL beq_outs: got %b want %b", {bus.State, bus.PCWriteCond, bus.PCWrite, bus.PCSource, bus.ALUOp},
               {4'd8, 1'b1, 1'b0, 2'b01, 6'b000100}); end
    tick();
    #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL beq_return: got %0d want 0", bus.State); end
  endtask

  task automatic test_jal();
    apply_reset();
    bus.Opcode = JAL; bus.Funct = 6'd0; bus.MemReady = 1'b1;
    tick(); tick();
    #1;
    total++; if (bus.State !== 4'd9) begin bad++; $display("FAIL jal_state: got %0d want 9", bus.State); end
    total++; if ({bus.PCWrite, bus.PCSource, bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 8'b1_10_1_10_10) begin bad++;
      $display("FAIL jal_outs: got %b want 11011010", {bus.PCWrite, bus.PCSource, bus.RegWrite, bus.RegDst, bus.MemtoReg}); end
    tick();
    #1;
    total++; if (bus.State !== 4'd0) begin bad++; $display("FAIL jal_return: got %0d want 0", bus.State); end
  endtask

  task automatic test_illegal();
    apply_reset();
    bus.Opcode = 6'b111111; bus.Funct = 6'd0; bus.MemReady = 1'b1;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      total++; if ({bus.State, bus.Fault} !== 5'b1111_1) begin bad++; $display("FAIL illegal_fault[%0d]: got %b want 11111", i, {bus.State, bus.Fault}); end
      total++; if ({bus.MemRead, bus.RegWrite, bus.PCWrite, bus.IRWrite, bus.MemWrite} !== 5'd0) begin bad++;
        $display("FAIL illegal_enables[%0d]: got %b want 00000", i, {bus.MemRead, bus.RegWrite, bus.PCWrite, bus.IRWrite, bus.MemWrite}); end
      tick();
    end
    reset = 1'b1;
    #1;
    total++; if (bus.Fault !== 1'b0) begin bad++; $display("FAIL illegal_reset_fault: got %b want 0", bus.Fault); end
    tick();
    reset = 1'b0;
    #1;
    total++; if ({bus.State, bus.Fault} !== 5'd0) begin bad++; $display("FAIL illegal_recover: got %b want 00000", {bus.State, bus.Fault}); end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.Opcode = BEQ; bus.Funct = 6'd0; bus.MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({bus.State, bus.MemRead, bus.IRWrite, bus.PCWrite} !== 7'b0000_100) begin bad++;
        $display("FAIL timeout_wait[%0d]: got %b want 0000100", i, {bus.State, bus.MemRead, bus.IRWrite, bus.PCWrite}); end
      tick();
    end
    #1;
    total++; if ({bus.State, bus.Fault} !== 5'b1111_1) begin bad++; $display("FAIL timeout_fault: got %b want 11111", {bus.State, bus.Fault}); end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.MemReady = (i == 3);
      #1;
      total++; if (bus.IRWrite !== (i == 3)) begin bad++; $display("FAIL late_ready_irwrite[%0d]: got %b want %b", i, bus.IRWrite, i == 3); end
      tick();
    end
    #1;
    total++; if ({bus.State, bus.Fault} !== 5'b0001_0) begin bad++; $display("FAIL late_ready_decode: got %b want 00010", {bus.State, bus.Fault}); end
  endtask

  task automatic test_reset_midwait();
    apply_reset();
    bus.Opcode = LW; bus.Funct = 6'd0; bus.MemReady = 1'b1;
    tick(); tick(); tick();
    bus.MemReady = 1'b0;
    tick(); tick();
    #1;
    total++; if ({bus.State, bus.MemRead, bus.IorD} !== 6'b0011_11) begin bad++; $display("FAIL midwait_memrd: got %b want 001111", {bus.State, bus.MemRead, bus.IorD}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // Counter must restart from zero: three more low cycles are still legal.
    for (int i = 0; i < 4; i++) begin
      bus.MemReady = (i == 3);
      #1;
      total++; if ({bus.State, bus.Fault} !== 5'd0) begin bad++; $display("FAIL midwait_fetch[%0d]: got %b want 00000", i, {bus.State, bus.Fault}); end
      tick();
    end
    #1;
    total++; if (bus.State !== 4'd1) begin bad++; $display("FAIL midwait_decode: got %0d want 1", bus.State); end
  endtask

  initial begin
    reset = 1'b1;
    bus.Opcode = 6'd0;
    bus.Funct = 6'd0;
    bus.MemReady = 1'b0;
    tick();
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype_jr();
    test_imm_beq();
    test_jal();
    test_illegal();
    test_timeout();
    test_reset_midwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
